// File: rtl/lcd_sequencer.sv
// HD44780 sequencer: waits out power-up, sends the init command list, then repaints
// a 2x16 frame from an external character store, paced on the nibble sender's busy.
module lcd_sequencer #(
  parameter int PWR_CYC     = 750000,
  parameter int CMD_CYC     = 2500,
  parameter int CLR_CYC     = 100000,
  parameter int REFRESH_CYC = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  input  logic       update,
  input  logic [7:0] char_data,
  output logic [4:0] char_addr,
  output logic [7:0] data_out,
  output logic       rs_out,
  output logic       send,
  output logic       ready
);

  localparam logic [23:0] PWR_LIM = 24'(PWR_CYC - 1);
  localparam logic [23:0] CMD_LIM = 24'(CMD_CYC - 1);
  localparam logic [23:0] CLR_LIM = 24'(CLR_CYC - 1);
  localparam logic [23:0] REF_LIM = 24'(REFRESH_CYC - 1);

  // Frame items: 0 = cmd 0x80, 1..16 = line 1 chars, 17 = cmd 0xC0, 18..33 = line 2 chars.
  localparam logic [5:0] LINE2_ITEM = 6'd17;
  localparam logic [5:0] LAST_ITEM  = 6'd33;
  localparam logic [2:0] LAST_INIT  = 3'd5;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT,
    XFER,
    ACK,
    DONE,
    DELAY,
    FRAME,
    FETCH,
    IDLE
  } state_t;

  state_t      state, state_next;
  logic [23:0] cnt;
  logic [23:0] delay_lim;
  logic        delay_done;
  logic [2:0]  init_idx;
  logic [5:0]  item;
  logic        pending;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    init_byte = 8'h01;
    case (idx)
      3'd0:    init_byte = 8'h33;
      3'd1:    init_byte = 8'h32;
      3'd2:    init_byte = 8'h28;
      3'd3:    init_byte = 8'h0C;
      3'd4:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  // data_out/rs_out still hold the byte just sent, so they select the post-transfer delay.
  assign delay_lim  = (!rs_out && data_out == 8'h01) ? CLR_LIM : CMD_LIM;
  assign delay_done = (cnt == delay_lim);
  assign send       = (state == XFER);

  always_comb begin
    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      PWR_WAIT: if (cnt == PWR_LIM) state_next = INIT;
      INIT:     state_next = XFER;
      XFER:     state_next = ACK;
      ACK:      if (busy) state_next = DONE;
      DONE:     if (!busy) state_next = DELAY;
      DELAY: begin
        if (delay_done) begin
          if (!ready) state_next = (init_idx == LAST_INIT) ? FRAME : INIT;
          else        state_next = (item == LAST_ITEM) ? IDLE : FRAME;
        end
      end
      FRAME:    state_next = (item == 6'd0 || item == LINE2_ITEM) ? XFER : FETCH;
      FETCH:    if (cnt == 24'd1) state_next = XFER;
      IDLE:     if (cnt == REF_LIM || pending || update) state_next = FRAME;
      default:  state_next = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      init_idx  <= '0;
      item      <= '0;
      pending   <= 1'b0;
      ready     <= 1'b0;
      char_addr <= '0;
      data_out  <= '0;
      rs_out    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state <= state_next;

      // One shared counter: cleared on every state change, so each wait starts from 0.
      if (state_next != state)
        cnt <= '0;
      else if (state inside {PWR_WAIT, DELAY, FETCH, IDLE})
        cnt <= cnt + 24'd1;

      if (update)
        pending <= 1'b1;
      else if (state == XFER && ready && item == 6'd0)
        pending <= 1'b0;

      case (state)
        INIT: begin
          data_out <= init_byte(init_idx);
          rs_out   <= 1'b0;
        end
        FRAME: begin
          if (item == 6'd0) begin
            data_out <= 8'h80;
            rs_out   <= 1'b0;
          end else if (item == LINE2_ITEM) begin
            data_out <= 8'hC0;
            rs_out   <= 1'b0;
          end else begin
            char_addr <= (item < LINE2_ITEM) ? 5'(item - 6'd1) : 5'(item - 6'd2);
          end
        end
        FETCH: begin
          if (cnt == 24'd1) begin
            data_out <= char_data;
            rs_out   <= 1'b1;
          end
        end
        DELAY: begin
          if (delay_done) begin
            if (!ready) begin
              if (init_idx == LAST_INIT) ready <= 1'b1;
              else                       init_idx <= init_idx + 3'd1;
            end else begin
              item <= (item == LAST_ITEM) ? 6'd0 : item + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: busy-holding sender model, 0x41+addr character
// store, expected bytes and send spacing queued ahead and compared on every send.
module tb_lcd_sequencer;

  localparam int PWR_CYC     = 20;
  localparam int CMD_CYC     = 5;
  localparam int CLR_CYC     = 10;
  localparam int REFRESH_CYC = 200;
  localparam int B_NOM       = 4;
  localparam int B_LONG      = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy = 1'b0;
  logic       update = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic [4:0] char_addr;
  logic [7:0] data_out;
  logic       rs_out;
  logic       send;
  logic       ready;

  lcd_sequencer #(
    .PWR_CYC    (PWR_CYC),
    .CMD_CYC    (CMD_CYC),
    .CLR_CYC    (CLR_CYC),
    .REFRESH_CYC(REFRESH_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .update   (update),
    .char_data(char_data),
    .char_addr(char_addr),
    .data_out (data_out),
    .rs_out   (rs_out),
    .send     (send),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [4:0] addr;
    int         gap;   // cycles since previous send; 0 = not checked
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_len = B_NOM;
  int busy_cnt = 0;
  int n_sends = 0;
  int first_send_cyc = 0;
  int last_send_cyc = 0;
  logic prev_send = 1'b0;
  bit   hold = 1'b0;
  bit   hold_seen_busy = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic       held_rs = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sender model: busy high for busy_len cycles starting the cycle after send is sampled.
  always @(posedge clk) begin
    char_data <= 8'h41 + {3'b000, char_addr};
    if (send) begin
      busy     <= 1'b1;
      busy_cnt <= busy_len - 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      n_sends   = 0;
      hold      = 1'b0;
      prev_send = 1'b0;
    end else begin
      if (send) begin
        check("no_send_while_busy", busy, 0);
        check("no_back_to_back_send", prev_send, 0);
        check("send_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("data_out", data_out, mon_e.data);
          check("rs_out", rs_out, mon_e.rs);
          check("ready", ready, mon_e.rdy);
          if (mon_e.rs) check("char_addr", char_addr, mon_e.addr);
          if (mon_e.gap != 0) check("send_gap", cyc - last_send_cyc, mon_e.gap);
        end
        if (n_sends == 0) first_send_cyc = cyc;
        n_sends++;
        last_send_cyc  = cyc;
        hold           = 1'b1;
        hold_seen_busy = 1'b0;
        held_data      = data_out;
        held_rs        = rs_out;
      end else if (hold) begin
        check("hold_data_out", data_out, held_data);
        check("hold_rs_out", rs_out, held_rs);
        if (busy) hold_seen_busy = 1'b1;
        else if (hold_seen_busy) hold = 1'b0;
      end
      prev_send = send;
    end
  end

  task automatic push(input logic [7:0] d, input logic r, input logic [4:0] a,
                      input int g, input logic rd);
    exp_t e;
    e.data = d;
    e.rs   = r;
    e.addr = a;
    e.gap  = g;
    e.rdy  = rd;
    sb.push_back(e);
  endtask

  // Command gap = ACK + busy + DELAY + INIT/FRAME; a character adds two FETCH cycles.
  task automatic push_init(input int b);
    push(8'h33, 1'b0, 5'd0, 0, 1'b0);
    push(8'h32, 1'b0, 5'd0, b + CMD_CYC + 3, 1'b0);
    push(8'h28, 1'b0, 5'd0, b + CMD_CYC + 3, 1'b0);
    push(8'h0C, 1'b0, 5'd0, b + CMD_CYC + 3, 1'b0);
    push(8'h06, 1'b0, 5'd0, b + CMD_CYC + 3, 1'b0);
    push(8'h01, 1'b0, 5'd0, b + CMD_CYC + 3, 1'b0);
  endtask

  task automatic push_frame(input int first_gap, input int b);
    push(8'h80, 1'b0, 5'd0, first_gap, 1'b1);
    for (int i = 0; i < 16; i++) push(8'h41 + 8'(i), 1'b1, 5'(i), b + CMD_CYC + 5, 1'b1);
    push(8'hC0, 1'b0, 5'd0, b + CMD_CYC + 3, 1'b1);
    for (int i = 16; i < 32; i++) push(8'h41 + 8'(i), 1'b1, 5'(i), b + CMD_CYC + 5, 1'b1);
  endtask

  task automatic wait_size(input int limit, input int budget, input string tag);
    int n = 0;
    while (sb.size() > limit && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size() <= limit, 1);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_char_addr", char_addr, 0);
    check("rst_data_out", data_out, 0);
    check("rst_rs_out", rs_out, 0);
    check("rst_send", send, 0);
    check("rst_ready", ready, 0);
    reset = 1'b0;

    // Power-up, init list, first frame (0x80 follows the longer clear delay).
    push_init(B_NOM);
    push_frame(B_NOM + CLR_CYC + 3, B_NOM);
    wait_size(0, 3000, "drain_init_frame1");
    check("first_send_cycle", first_send_cyc, PWR_CYC + 1);
    check("ready_sticky", ready, 1);

    // Second frame after the full refresh wait; an update mid-frame yields one extra frame.
    push_frame(B_NOM + CMD_CYC + 3 + REFRESH_CYC, B_NOM);
    wait_size(30, 2000, "frame2_progress");
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
    push_frame(B_NOM + CMD_CYC + 4, B_NOM);
    push_frame(B_NOM + CMD_CYC + 3 + REFRESH_CYC, B_NOM);
    wait_size(0, 3000, "drain_update_midframe");

    // Update at IDLE cycle 10: 0x80 goes out two cycles later.
    push_frame(B_NOM + CMD_CYC + 14, B_NOM);
    wait_cyc(last_send_cyc + B_NOM + CMD_CYC + 12);
    update = 1'b1;
    @(negedge clk) update = 1'b0;
    wait_size(0, 2000, "drain_update_idle");

    // Slow sender: busy held 100 cycles per transfer.
    busy_len = B_LONG;
    push_frame(B_NOM + CMD_CYC + 3 + REFRESH_CYC, B_LONG);
    wait_size(0, 6000, "drain_long_busy");

    // Reset asserted during DONE of the third transfer of a frame.
    busy_len = B_NOM;
    push_frame(B_LONG + CMD_CYC + 3 + REFRESH_CYC, B_NOM);
    wait_size(31, 2000, "frame7_progress");
    wait_cyc(last_send_cyc + 3);
    #2 reset = 1'b1;
    #1;
    check("midrst_char_addr", char_addr, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_rs_out", rs_out, 0);
    check("midrst_send", send, 0);
    check("midrst_ready", ready, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_init(B_NOM);
    wait_size(0, 1000, "drain_restart_init");
    check("restart_first_send_cycle", first_send_cyc, PWR_CYC + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
